// File: rtl/nes_pkg.sv
// Shared types and constants for the iNES boot loader.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        TRAIN,
        PRG,
        CHR,
        DONE,
        ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_MAGIC  = 2'd1,
        ERR_SIZE   = 2'd2,
        ERR_MAPPER = 2'd3
    } err_code_t;

    // "NES\x1A" with byte 0 in the least significant position
    localparam logic [31:0] INES_MAGIC   = 32'h1A53454E;
    localparam int unsigned INES_HDR_LEN = 16;

endpackage

// File: rtl/ines_hdr_check.sv
// Combinational check of one iNES header byte against its position.
module ines_hdr_check
    import nes_pkg::*;
(
    input  logic [3:0] idx,
    input  logic [7:0] hdr_byte,
    input  logic [3:0] mapper_lo,
    output logic       pass,
    output err_code_t  code
);

    logic [7:0] magic_byte;

    always_comb begin
        magic_byte = INES_MAGIC[{idx[1:0], 3'b000} +: 8];
        pass       = 1'b1;
        code       = ERR_NONE;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                if (hdr_byte != magic_byte) begin
                    pass = 1'b0;
                    code = ERR_MAGIC;
                end
            end
            4'd4: begin
                if (hdr_byte != 8'd1) begin
                    pass = 1'b0;
                    code = ERR_SIZE;
                end
            end
            4'd5: begin
                if (hdr_byte > 8'd1) begin
                    pass = 1'b0;
                    code = ERR_SIZE;
                end
            end
            // Mapper number is split across bytes 6 and 7; the low nibble was latched earlier
            4'd7: begin
                if ({hdr_byte[7:4], mapper_lo} != 8'd0) begin
                    pass = 1'b0;
                    code = ERR_MAPPER;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ines_prg_loader.sv
// Boot-time iNES image loader: validates the header, skips the trainer,
// fills PRG/CHR ROMs and releases the CPU reset once the image is in place.
module ines_prg_loader
    import nes_pkg::*;
#(
    parameter int unsigned PRG_AW      = 14,
    parameter int unsigned CHR_AW      = 13,
    parameter int unsigned HDR_LEN     = INES_HDR_LEN,
    parameter int unsigned TRAINER_LEN = 512
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prg_we,
    output logic [PRG_AW-1:0] prg_addr,
    output logic [7:0]        prg_wdata,
    output logic              chr_we,
    output logic [CHR_AW-1:0] chr_addr,
    output logic [7:0]        chr_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              cpu_rst_n
);

    localparam int unsigned TRN_W = $clog2(TRAINER_LEN);
    localparam int unsigned W0    = (PRG_AW > CHR_AW) ? PRG_AW : CHR_AW;
    localparam int unsigned W1    = (W0 > TRN_W) ? W0 : TRN_W;
    localparam int unsigned CNT_W = (W1 > 4) ? W1 : 4;

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;
    logic              prg_we_q, prg_we_d;
    logic [PRG_AW-1:0] prg_addr_q, prg_addr_d;
    logic [7:0]        prg_wdata_q, prg_wdata_d;
    logic              chr_we_q, chr_we_d;
    logic [CHR_AW-1:0] chr_addr_q, chr_addr_d;
    logic [7:0]        chr_wdata_q, chr_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    err_code_t         err_code_q, err_code_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              chr_units_q, chr_units_d;
    logic              trainer_q, trainer_d;
    logic [3:0]        mapper_lo_q, mapper_lo_d;

    logic              accept;
    logic              hdr_pass;
    err_code_t         hdr_code;

    assign accept = in_valid && in_ready_q;

    ines_hdr_check u_hdr_check (
        .idx       (cnt_q[3:0]),
        .hdr_byte  (in_data),
        .mapper_lo (mapper_lo_q),
        .pass      (hdr_pass),
        .code      (hdr_code)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prg_we_d    = 1'b0;
        prg_addr_d  = prg_addr_q;
        prg_wdata_d = prg_wdata_q;
        chr_we_d    = 1'b0;
        chr_addr_d  = chr_addr_q;
        chr_wdata_d = chr_wdata_q;
        err_code_d  = err_code_q;
        chr_units_d = chr_units_q;
        trainer_d   = trainer_q;
        mapper_lo_d = mapper_lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = HDR;
                    cnt_d   = '0;
                end
            end
            HDR: begin
                if (accept) begin
                    if (!hdr_pass) begin
                        state_d    = ERROR;
                        err_code_d = hdr_code;
                    end else begin
                        if (cnt_q[3:0] == 4'd5) chr_units_d = in_data[0];
                        if (cnt_q[3:0] == 4'd6) begin
                            trainer_d   = in_data[2];
                            mapper_lo_d = in_data[7:4];
                        end
                        if (cnt_q[3:0] == 4'(HDR_LEN - 1)) begin
                            cnt_d   = '0;
                            state_d = trainer_q ? TRAIN : PRG;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            TRAIN: begin
                if (accept) begin
                    if (cnt_q == CNT_W'(TRAINER_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = PRG;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PRG: begin
                if (accept) begin
                    prg_we_d    = 1'b1;
                    prg_addr_d  = cnt_q[PRG_AW-1:0];
                    prg_wdata_d = in_data;
                    if (&cnt_q[PRG_AW-1:0]) begin
                        cnt_d   = '0;
                        state_d = chr_units_q ? CHR : DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CHR: begin
                if (accept) begin
                    chr_we_d    = 1'b1;
                    chr_addr_d  = cnt_q[CHR_AW-1:0];
                    chr_wdata_d = in_data;
                    if (&cnt_q[CHR_AW-1:0]) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE, ERROR: begin
                if (start) begin
                    state_d    = HDR;
                    cnt_d      = '0;
                    err_code_d = ERR_NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status follows the next state, except that DONE's status lags by one
        // cycle so it appears only after the final write strobe has retired.
        in_ready_d  = (state_d == HDR) || (state_d == TRAIN) ||
                      (state_d == PRG) || (state_d == CHR);
        error_d     = (state_d == ERROR);
        done_d      = (state_q == DONE) && (state_d == DONE);
        cpu_rst_n_d = done_d;
        busy_d      = in_ready_d || ((state_d == DONE) && (state_q != DONE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            prg_we_q    <= 1'b0;
            prg_addr_q  <= '0;
            prg_wdata_q <= '0;
            chr_we_q    <= 1'b0;
            chr_addr_q  <= '0;
            chr_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            cpu_rst_n_q <= 1'b0;
            chr_units_q <= 1'b0;
            trainer_q   <= 1'b0;
            mapper_lo_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            prg_we_q    <= prg_we_d;
            prg_addr_q  <= prg_addr_d;
            prg_wdata_q <= prg_wdata_d;
            chr_we_q    <= chr_we_d;
            chr_addr_q  <= chr_addr_d;
            chr_wdata_q <= chr_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            chr_units_q <= chr_units_d;
            trainer_q   <= trainer_d;
            mapper_lo_q <= mapper_lo_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign prg_we    = prg_we_q;
    assign prg_addr  = prg_addr_q;
    assign prg_wdata = prg_wdata_q;
    assign chr_we    = chr_we_q;
    assign chr_addr  = chr_addr_q;
    assign chr_wdata = chr_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_ines_prg_loader.sv
// Directed bench for ines_prg_loader: header-error table plus full-image load sequences.
module tb_ines_prg_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        prg_we;
    logic [13:0] prg_addr;
    logic [7:0]  prg_wdata;
    logic        chr_we;
    logic [12:0] chr_addr;
    logic [7:0]  chr_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;
    logic        cpu_rst_n;

    ines_prg_loader #(
        .PRG_AW      (14),
        .CHR_AW      (13),
        .HDR_LEN     (16),
        .TRAINER_LEN (512)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prg_we    (prg_we),
        .prg_addr  (prg_addr),
        .prg_wdata (prg_wdata),
        .chr_we    (chr_we),
        .chr_addr  (chr_addr),
        .chr_wdata (chr_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit abort = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_prg(input int mode, input int i);
        if (mode == 1) return 8'((i * 7 + 3) & 255);
        return 8'(i & 255);
    endfunction

    function automatic logic [127:0] mk_hdr(input logic [7:0] b0, input logic [7:0] b2,
                                            input logic [7:0] b4, input logic [7:0] b5,
                                            input logic [7:0] b6, input logic [7:0] b7,
                                            input logic [7:0] fill);
        return {{8{fill}}, b7, b6, b5, b4, 8'h1A, b2, 8'h45, b0};
    endfunction

    // Write monitor: tallies strobes and mismatches against the expected stream
    bit mon_en = 1'b0;
    bit mon_clr = 1'b0;
    int cur_mode = 0;
    int prg_seen, prg_bad, chr_seen, chr_bad, both_hi, rdy_drop;
    logic [7:0] first_prg;

    always @(negedge clk) begin
        if (mon_clr) begin
            prg_seen = 0; prg_bad = 0; chr_seen = 0; chr_bad = 0;
            both_hi = 0; rdy_drop = 0; first_prg = 8'h00;
        end else if (mon_en) begin
            if (prg_we && chr_we) both_hi++;
            if (prg_we) begin
                if (prg_seen == 0) first_prg = prg_wdata;
                if (prg_addr !== 14'(prg_seen) || prg_wdata !== exp_prg(cur_mode, prg_seen)) prg_bad++;
                prg_seen++;
            end
            if (chr_we) begin
                if (chr_addr !== 13'(chr_seen) || chr_wdata !== 8'h55) chr_bad++;
                chr_seen++;
            end
            if (prg_seen >= 1 && prg_seen < 16384 && !in_ready) rdy_drop++;
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        if (abort) return;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        acc      = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) begin
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            abort = 1'b1;
            $display("FAIL accept_timeout: in_ready=%0b, expected 1", in_ready);
        end
    endtask

    task automatic run_image(input string name, input logic [127:0] hdr, input bit trainer,
                             input bit chr_units, input bit gaps, input int mode);
        cur_mode = mode;
        in_valid = 1'b0;
        clear_mon();
        mon_en = 1'b1;
        pulse_start();
        chk({name, "_start_busy"}, busy, 1);
        chk({name, "_start_err_code"}, err_code, 0);
        chk({name, "_start_error"}, error, 0);
        chk({name, "_start_done"}, done, 0);
        chk({name, "_start_cpu_rst"}, cpu_rst_n, 0);
        for (int i = 0; i < 16; i++) send_byte(hdr[8*i +: 8], gaps);
        if (trainer) begin
            for (int i = 0; i < 512; i++) send_byte(8'hAA, gaps);
            chk({name, "_trainer_no_write"}, prg_seen + chr_seen, 0);
        end
        for (int i = 0; i < 16384 && !abort; i++) begin
            if (gaps && i == 5000) begin
                in_valid = 1'b0;
                pulse_start();
                chk({name, "_mid_start_busy"}, busy, 1);
                chk({name, "_mid_start_ready"}, in_ready, 1);
            end
            send_byte(exp_prg(mode, i), gaps);
            if (i == 0) begin
                chk({name, "_first_we"}, prg_we, 1);
                chk({name, "_first_addr"}, prg_addr, 0);
                chk({name, "_first_data"}, prg_wdata, exp_prg(mode, 0));
            end
        end
        if (chr_units) begin
            for (int i = 0; i < 8192 && !abort; i++) send_byte(8'h55, gaps);
            chk({name, "_last_chr_we"}, chr_we, 1);
            chk({name, "_last_chr_addr"}, chr_addr, 13'h1FFF);
        end else begin
            chk({name, "_last_prg_we"}, prg_we, 1);
            chk({name, "_last_prg_addr"}, prg_addr, 14'h3FFF);
        end
        chk({name, "_done_not_early"}, done, 0);
        chk({name, "_cpu_rst_not_early"}, cpu_rst_n, 0);
        in_data = 8'h99;
        @(posedge clk);
        #1;
        chk({name, "_done"}, done, 1);
        chk({name, "_cpu_rst_released"}, cpu_rst_n, 1);
        chk({name, "_busy_low"}, busy, 0);
        chk({name, "_we_low"}, {prg_we, chr_we}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_no_extra_consume"}, in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk({name, "_prg_count"}, prg_seen, 16384);
        chk({name, "_prg_mismatches"}, prg_bad, 0);
        chk({name, "_chr_count"}, chr_seen, chr_units ? 8192 : 0);
        chk({name, "_chr_mismatches"}, chr_bad, 0);
        chk({name, "_we_overlap"}, both_hi, 0);
        chk({name, "_ready_drop"}, rdy_drop, 0);
        chk({name, "_first_prg_byte"}, first_prg, exp_prg(mode, 0));
        mon_en = 1'b0;
    endtask

    typedef struct {
        string        name;
        logic [127:0] hdr;
        int           last;
        logic [1:0]   code;
    } hdr_case_t;

    hdr_case_t tbl[6];

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"bad_magic2", mk_hdr(8'h4E, 8'h54, 8'h01, 8'h00, 8'h00, 8'h00, 8'hEE), 2, 2'd1};
        tbl[1] = '{"prg_units2", mk_hdr(8'h4E, 8'h53, 8'h02, 8'h00, 8'h00, 8'h00, 8'hEE), 4, 2'd2};
        tbl[2] = '{"chr_units2", mk_hdr(8'h4E, 8'h53, 8'h01, 8'h02, 8'h00, 8'h00, 8'hEE), 5, 2'd2};
        tbl[3] = '{"mapper_lo",  mk_hdr(8'h4E, 8'h53, 8'h01, 8'h00, 8'h10, 8'h00, 8'hEE), 7, 2'd3};
        tbl[4] = '{"mapper_hi",  mk_hdr(8'h4E, 8'h53, 8'h01, 8'h01, 8'h00, 8'h10, 8'hEE), 7, 2'd3};
        tbl[5] = '{"bad_magic0", mk_hdr(8'h00, 8'h53, 8'h01, 8'h00, 8'h00, 8'h00, 8'hEE), 0, 2'd1};

        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_we", {prg_we, chr_we}, 0);
        chk("rst_addr", {prg_addr, chr_addr}, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_busy", busy, 0);

        for (int r = 0; r < 6; r++) begin
            clear_mon();
            mon_en = 1'b1;
            if (r == 0) begin
                in_valid = 1'b1;
                in_data  = 8'h4E;
            end else begin
                in_valid = 1'b0;
            end
            pulse_start();
            chk({tbl[r].name, "_start_busy"}, busy, 1);
            chk({tbl[r].name, "_start_error_clr"}, error, 0);
            chk({tbl[r].name, "_start_code_clr"}, err_code, 0);
            for (int i = 0; i <= tbl[r].last; i++) begin
                if (i == tbl[r].last && i > 0) chk({tbl[r].name, "_no_early_error"}, error, 0);
                send_byte(tbl[r].hdr[8*i +: 8], 1'b0);
            end
            in_data = 8'h4E;
            chk({tbl[r].name, "_error"}, error, 1);
            chk({tbl[r].name, "_code"}, err_code, tbl[r].code);
            chk({tbl[r].name, "_in_ready"}, in_ready, 0);
            chk({tbl[r].name, "_busy"}, busy, 0);
            chk({tbl[r].name, "_cpu_rst_n"}, cpu_rst_n, 0);
            repeat (3) @(posedge clk);
            #1;
            chk({tbl[r].name, "_ready_held_low"}, in_ready, 0);
            chk({tbl[r].name, "_code_held"}, err_code, tbl[r].code);
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            chk({tbl[r].name, "_no_strobes"}, prg_seen + chr_seen, 0);
            mon_en = 1'b0;
        end

        run_image("plain", mk_hdr(8'h4E, 8'h53, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, 1'b0, 0);
        run_image("trn_chr", mk_hdr(8'h4E, 8'h53, 8'h01, 8'h01, 8'h04, 8'h00, 8'h00), 1'b1, 1'b1, 1'b0, 1);

        // Reset mid-PRG, then a complete load with random stalls
        if (!abort) begin
            pulse_start();
            for (int i = 0; i < 16; i++) send_byte(8'(mk_hdr(8'h4E, 8'h53, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00) >> (8 * i)), 1'b0);
            for (int i = 0; i < 100; i++) send_byte(exp_prg(0, i), 1'b0);
            chk("pre_rst_addr", prg_addr, 14'd99);
            #2 rst_n = 1'b0;
            #1;
            chk("midrst_in_ready", in_ready, 0);
            chk("midrst_prg_we", prg_we, 0);
            chk("midrst_prg_addr", prg_addr, 0);
            chk("midrst_busy", busy, 0);
            chk("midrst_done_error", {done, error}, 0);
            chk("midrst_cpu_rst_n", cpu_rst_n, 0);
            in_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            run_image("gapped", mk_hdr(8'h4E, 8'h53, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00), 1'b0, 1'b0, 1'b1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
